id_ex_reg: RTL and testbench

- Decode-to-execute pipeline register of the 5-stage MIPS pipeline; captures decoded operands and control from D and presents them to the E-stage ALU.
- Also holds the E-stage operand forwarding muxes, so alu_a/alu_b connect straight to the ALU A/B inputs.
- Tracks Tnew (cycles until the result is produced) and handles hold, bubble and flush.

---
 rtl/id_ex_reg.sv | 129 ++++++++++++
 tb/tb_id_ex_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// id_ex_reg: D->E pipeline register with E-stage operand forwarding muxes.
// Revision: 1.0 - initial release
`default_nettype none

module id_ex_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold_E,
  input  logic             bubble,
  input  logic [WIDTH-1:0] instr_D,
  input  logic [WIDTH-1:0] pc_D,
  input  logic [WIDTH-1:0] rs_data_D,
  input  logic [WIDTH-1:0] rt_data_D,
  input  logic [WIDTH-1:0] imm_D,
  input  logic [2:0]       alu_op_D,
  input  logic             alu_src_D,
  input  logic             reg_write_D,
  input  logic [4:0]       write_reg_D,
  input  logic             mem_to_reg_D,
  input  logic             mem_write_D,
  input  logic [1:0]       tnew_D,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] fwd_m_data,
  input  logic [WIDTH-1:0] fwd_w_data,
  output logic [WIDTH-1:0] instr_E,
  output logic [WIDTH-1:0] pc_E,
  output logic [WIDTH-1:0] rs_E,
  output logic [WIDTH-1:0] rt_E,
  output logic [WIDTH-1:0] imm_E,
  output logic [2:0]       alu_op_E,
  output logic             reg_write_E,
  output logic             mem_to_reg_E,
  output logic             mem_write_E,
  output logic [4:0]       write_reg_E,
  output logic [1:0]       tnew_E,
  output logic [1:0]       tnew_M_next,
  output logic             valid_E,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] rt_fwd_E
);

  logic             alu_src_E;
  logic [WIDTH-1:0] fa;
  logic [WIDTH-1:0] fb;

  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_E      <= '0;
      pc_E         <= '0;
      rs_E         <= '0;
      rt_E         <= '0;
      imm_E        <= '0;
      alu_op_E     <= 3'd0;
      alu_src_E    <= 1'b0;
      reg_write_E  <= 1'b0;
      write_reg_E  <= 5'd0;
      mem_to_reg_E <= 1'b0;
      mem_write_E  <= 1'b0;
      tnew_E       <= 2'd0;
      valid_E      <= 1'b0;
    end else if (flush || (!hold_E && bubble)) begin
      // Bubble keeps the D-stage PC so a later exception still has a valid EPC.
      instr_E      <= '0;
      pc_E         <= flush ? '0 : pc_D;
      rs_E         <= '0;
      rt_E         <= '0;
      imm_E        <= '0;
      alu_op_E     <= 3'd0;
      alu_src_E    <= 1'b0;
      reg_write_E  <= 1'b0;
      write_reg_E  <= 5'd0;
      mem_to_reg_E <= 1'b0;
      mem_write_E  <= 1'b0;
      tnew_E       <= 2'd0;
      valid_E      <= 1'b0;
    end else if (!hold_E) begin
      instr_E      <= instr_D;
      pc_E         <= pc_D;
      rs_E         <= rs_data_D;
      rt_E         <= rt_data_D;
      imm_E        <= imm_D;
      alu_op_E     <= alu_op_D;
      alu_src_E    <= alu_src_D;
      reg_write_E  <= reg_write_D;
      write_reg_E  <= write_reg_D;
      mem_to_reg_E <= mem_to_reg_D;
      mem_write_E  <= mem_write_D;
      tnew_E       <= sat_dec(tnew_D);
      valid_E      <= 1'b1;
    end
  end

  assign tnew_M_next = sat_dec(tnew_E);

  // Select code 11 is reserved and falls back to the registered operand.
  always_comb begin
    fa = rs_E;
    case (fwd_a_sel)
      2'b01:   fa = fwd_m_data;
      2'b10:   fa = fwd_w_data;
      default: fa = rs_E;
    endcase
  end

  always_comb begin
    fb = rt_E;
    case (fwd_b_sel)
      2'b01:   fb = fwd_m_data;
      2'b10:   fb = fwd_w_data;
      default: fb = rt_E;
    endcase
  end

  assign alu_a    = fa;
  assign alu_b    = alu_src_E ? imm_E : fb;
  assign rt_fwd_E = fb;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed checks of capture, forwarding, bubble, hold, flush and reset.
`default_nettype none

module tb_id_ex_reg;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset, flush, hold_E, bubble;
  logic [WIDTH-1:0] instr_D, pc_D, rs_data_D, rt_data_D, imm_D;
  logic [2:0]       alu_op_D;
  logic             alu_src_D, reg_write_D, mem_to_reg_D, mem_write_D;
  logic [4:0]       write_reg_D;
  logic [1:0]       tnew_D, fwd_a_sel, fwd_b_sel;
  logic [WIDTH-1:0] fwd_m_data, fwd_w_data;
  logic [WIDTH-1:0] instr_E, pc_E, rs_E, rt_E, imm_E;
  logic [2:0]       alu_op_E;
  logic             reg_write_E, mem_to_reg_E, mem_write_E, valid_E;
  logic [4:0]       write_reg_E;
  logic [1:0]       tnew_E, tnew_M_next;
  logic [WIDTH-1:0] alu_a, alu_b, rt_fwd_E;

  int total = 0;
  int bad   = 0;

  id_ex_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold_E(hold_E), .bubble(bubble),
    .instr_D(instr_D), .pc_D(pc_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
    .imm_D(imm_D), .alu_op_D(alu_op_D), .alu_src_D(alu_src_D),
    .reg_write_D(reg_write_D), .write_reg_D(write_reg_D),
    .mem_to_reg_D(mem_to_reg_D), .mem_write_D(mem_write_D), .tnew_D(tnew_D),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_m_data(fwd_m_data), .fwd_w_data(fwd_w_data),
    .instr_E(instr_E), .pc_E(pc_E), .rs_E(rs_E), .rt_E(rt_E), .imm_E(imm_E),
    .alu_op_E(alu_op_E), .reg_write_E(reg_write_E), .mem_to_reg_E(mem_to_reg_E),
    .mem_write_E(mem_write_E), .write_reg_E(write_reg_E), .tnew_E(tnew_E),
    .tnew_M_next(tnew_M_next), .valid_E(valid_E),
    .alu_a(alu_a), .alu_b(alu_b), .rt_fwd_E(rt_fwd_E)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; hold_E = 1'b0; bubble = 1'b0;
    instr_D = '0; pc_D = '0; rs_data_D = '0; rt_data_D = '0; imm_D = '0;
    alu_op_D = 3'd0; alu_src_D = 1'b0; reg_write_D = 1'b0; write_reg_D = 5'd0;
    mem_to_reg_D = 1'b0; mem_write_D = 1'b0; tnew_D = 2'd0;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; fwd_m_data = '0; fwd_w_data = '0;
    #2;
    check("rst_valid", 32'(valid_E), 32'd0);
    check("rst_pc", pc_E, 32'd0);
    check("rst_tnew", 32'(tnew_E), 32'd0);
    step();
    reset = 1'b0;

    // Basic capture
    pc_D = 32'h3000; rs_data_D = 32'd5; rt_data_D = 32'd7; alu_op_D = 3'b001;
    tnew_D = 2'd2; alu_src_D = 1'b0; instr_D = 32'h0123_4567;
    step();
    check("cap_pc", pc_E, 32'h3000);
    check("cap_alu_a", alu_a, 32'd5);
    check("cap_alu_b", alu_b, 32'd7);
    check("cap_tnew", 32'(tnew_E), 32'd1);
    check("cap_tnew_m", 32'(tnew_M_next), 32'd0);
    check("cap_valid", 32'(valid_E), 32'd1);
    check("cap_alu_op", 32'(alu_op_E), 32'd1);

    // Immediate select and forwarding
    imm_D = 32'h10; alu_src_D = 1'b1;
    step();
    fwd_a_sel = 2'b01; fwd_m_data = 32'hABCD;
    #1;
    check("fwd_a_m", alu_a, 32'hABCD);
    check("imm_alu_b", alu_b, 32'h10);
    fwd_b_sel = 2'b10; fwd_w_data = 32'd9;
    #1;
    check("fwd_b_w", rt_fwd_E, 32'd9);
    check("imm_alu_b2", alu_b, 32'h10);
    fwd_a_sel = 2'b10;
    #1;
    check("fwd_a_w", alu_a, 32'd9);
    fwd_a_sel = 2'b11; fwd_b_sel = 2'b01;
    #1;
    check("fwd_a_rsv", alu_a, 32'd5);
    check("fwd_b_m", rt_fwd_E, 32'hABCD);
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;

    // Bubble
    alu_src_D = 1'b0; reg_write_D = 1'b1; instr_D = 32'h1234;
    step();
    check("pre_bub_rw", 32'(reg_write_E), 32'd1);
    bubble = 1'b1; pc_D = 32'h3004;
    step();
    bubble = 1'b0;
    check("bub_valid", 32'(valid_E), 32'd0);
    check("bub_rw", 32'(reg_write_E), 32'd0);
    check("bub_instr", instr_E, 32'd0);
    check("bub_pc", pc_E, 32'h3004);
    check("bub_tnew", 32'(tnew_E), 32'd0);

    // Hold beats bubble
    instr_D = 32'hAAAA_0001; pc_D = 32'h3008; rs_data_D = 32'h11; rt_data_D = 32'h22;
    imm_D = 32'h33; alu_op_D = 3'b010; alu_src_D = 1'b0; reg_write_D = 1'b1;
    write_reg_D = 5'd5; mem_to_reg_D = 1'b1; mem_write_D = 1'b1; tnew_D = 2'd3;
    step();
    check("hcap_tnew", 32'(tnew_E), 32'd2);
    check("hcap_tnew_m", 32'(tnew_M_next), 32'd1);
    hold_E = 1'b1; bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_D = 32'hBBBB_0000 + 32'(i); pc_D = 32'h4000 + 32'(i);
      rs_data_D = 32'h100 + 32'(i); rt_data_D = 32'h200 + 32'(i);
      alu_op_D = 3'b011; write_reg_D = 5'd9; mem_write_D = 1'b0; tnew_D = 2'd1;
      step();
      check("hold_instr", instr_E, 32'hAAAA_0001);
      check("hold_pc", pc_E, 32'h3008);
      check("hold_rs", rs_E, 32'h11);
      check("hold_valid", 32'(valid_E), 32'd1);
      check("hold_tnew", 32'(tnew_E), 32'd2);
      check("hold_mw", 32'(mem_write_E), 32'd1);
      check("hold_wreg", 32'(write_reg_E), 32'd5);
      check("hold_alu_op", 32'(alu_op_E), 32'd2);
    end
    hold_E = 1'b0; bubble = 1'b0;
    step();
    check("rel_instr", instr_E, 32'hBBBB_0002);
    check("rel_pc", pc_E, 32'h4002);
    check("rel_rt", rt_E, 32'h202);
    check("rel_wreg", 32'(write_reg_E), 32'd9);
    check("rel_tnew", 32'(tnew_E), 32'd0);

    // Flush beats hold and bubble
    mem_write_D = 1'b1; pc_D = 32'h5000;
    step();
    check("pre_fl_mw", 32'(mem_write_E), 32'd1);
    flush = 1'b1; hold_E = 1'b1; bubble = 1'b1;
    step();
    flush = 1'b0; hold_E = 1'b0; bubble = 1'b0;
    check("fl_pc", pc_E, 32'd0);
    check("fl_valid", 32'(valid_E), 32'd0);
    check("fl_mw", 32'(mem_write_E), 32'd0);

    // Asynchronous reset between edges, then saturating decrement of zero
    step();
    check("pre_ar_valid", 32'(valid_E), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", 32'(valid_E), 32'd0);
    check("ar_pc", pc_E, 32'd0);
    check("ar_instr", instr_E, 32'd0);
    #1 reset = 1'b0;
    tnew_D = 2'd0;
    step();
    check("sat_tnew", 32'(tnew_E), 32'd0);
    check("sat_tnew_m", 32'(tnew_M_next), 32'd0);
    check("sat_valid", 32'(valid_E), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
